// File: rtl/faxi_pkg.sv
// Shared encodings for the AXI read responder: burst types, response codes,
// responder FSM states and the WRAP-length helper used by the address unit.
package faxi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_RSVD  = 2'b10,
    BURST_WRAP  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DATA  = 2'b10
  } state_e;

  // log2(beats) for the legal WRAP lengths; 0 flags an illegal WRAP length.
  function automatic logic [2:0] wrap_lg2(input logic [7:0] len);
    case (len)
      8'd1:    return 3'd1;
      8'd3:    return 3'd2;
      8'd7:    return 3'd3;
      8'd15:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/faxi_address.sv
// Burst next-address arithmetic: FIXED holds, INCR steps and aligns,
// WRAP steps within the naturally aligned window of beats*bytes.
module faxi_address
  import faxi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_size,
  input  burst_e        i_burst,
  input  logic [7:0]    i_len,
  output logic [AW-1:0] o_next
);

  logic [AW-1:0] step;
  logic [AW-1:0] incr;
  logic [AW-1:0] aligned;
  logic [AW-1:0] wmask;
  logic [3:0]    wshift;

  always_comb begin
    step    = AW'(1) << i_size;
    incr    = i_addr + step;
    aligned = incr & ~(step - AW'(1));
    wshift  = {1'b0, i_size} + {1'b0, wrap_lg2(i_len)};
    wmask   = (AW'(1) << wshift) - AW'(1);
    case (i_burst)
      BURST_FIXED: o_next = i_addr;
      BURST_WRAP:  o_next = (i_addr & ~wmask) | (aligned & wmask);
      default:     o_next = aligned;
    endcase
  end

endmodule

// File: rtl/faxi_rd_slave.sv
// AXI4 read-channel responder for a single-port synchronous RAM: one burst
// at a time, one memory read per beat, SLVERR beats for illegal requests.
module faxi_rd_slave
  import faxi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_arvalid,
  output logic          o_arready,
  input  logic [AW-1:0] i_araddr,
  input  logic [7:0]    i_arlen,
  input  logic [2:0]    i_arsize,
  input  logic [1:0]    i_arburst,
  input  logic [IW-1:0] i_arid,
  output logic          o_rvalid,
  input  logic          i_rready,
  output logic [DW-1:0] o_rdata,
  output logic [1:0]    o_rresp,
  output logic          o_rlast,
  output logic [IW-1:0] o_rid,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data
);

  localparam int SZ_MAX = $clog2(DW / 8);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    size_q, size_d;
  burst_e        burst_q, burst_d;
  logic [IW-1:0] id_q, id_d;
  logic          err_q, err_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  resp_e         rresp_q, rresp_d;
  logic          rlast_q, rlast_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          fresh_q, fresh_d;
  logic [AW-1:0] next_addr;
  logic          capture;
  logic          illegal;

  faxi_address #(.AW(AW)) u_addr (
    .i_addr  (addr_q),
    .i_size  (size_q),
    .i_burst (burst_q),
    .i_len   (len_q),
    .o_next  (next_addr)
  );

  assign capture = i_arvalid && arready_q;
  assign illegal = (i_arburst == BURST_RSVD) || (int'(i_arsize) > SZ_MAX) ||
                   ((i_arburst == BURST_WRAP) && (wrap_lg2(i_arlen) == 3'd0));

  // Memory data is valid only in the first DATA cycle after a fetch; it is
  // bypassed then and held in rdata_q for any backpressured cycles after.
  assign o_rdata   = fresh_q ? i_rd_data : rdata_q;
  assign o_rd_en   = (state_q == ST_FETCH);
  assign o_rd_addr = o_rd_en ? addr_q : '0;
  assign o_arready = arready_q;
  assign o_rvalid  = rvalid_q;
  assign o_rresp   = rresp_q;
  assign o_rlast   = rlast_q;
  assign o_rid     = rid_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    burst_d  = burst_q;
    id_d     = id_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    rdata_d  = fresh_q ? i_rd_data : rdata_q;
    fresh_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          addr_d  = i_araddr;
          len_d   = i_arlen;
          cnt_d   = i_arlen;
          size_d  = i_arsize;
          burst_d = burst_e'(i_arburst);
          id_d    = i_arid;
          err_d   = illegal;
          if (illegal) begin
            state_d  = ST_DATA;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rlast_d  = (i_arlen == 8'd0);
            rid_d    = i_arid;
            rdata_d  = '0;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_d  = ST_DATA;
        rvalid_d = 1'b1;
        rresp_d  = RESP_OKAY;
        rlast_d  = (cnt_q == 8'd0);
        rid_d    = id_q;
        fresh_d  = 1'b1;
      end
      ST_DATA: begin
        if (i_rready) begin
          if (rlast_q) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = next_addr;
            if (err_q) begin
              // Error beats stream back-to-back with no memory access.
              rlast_d = (cnt_q == 8'd1);
              rdata_d = '0;
            end else begin
              state_d  = ST_FETCH;
              rvalid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      id_q      <= '0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      fresh_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      id_q      <= id_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      fresh_q   <= fresh_d;
    end
  end

endmodule

// File: tb/tb_faxi_rd_slave.sv
// Scoreboard bench for faxi_rd_slave: expected beats are queued at AR time
// from an independent address model and popped on each R handshake.
module tb_faxi_rd_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic [IW-1:0] arid = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [IW-1:0] rid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  faxi_rd_slave #(.AW(AW), .DW(DW), .IW(IW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst), .i_arid(arid),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .o_rlast(rlast), .o_rid(rid),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // RAM model: data valid only in the cycle after a read, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem_word(rd_addr) : 32'hDEAD_BEEF;

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a0, input int len,
                                               input int size, input logic [1:0] burst,
                                               input int i);
    longint a     = longint'(a0);
    longint bytes = longint'(1) << size;
    longint total = bytes * (len + 1);
    longint al    = (a / bytes) * bytes;
    longint base  = (a / total) * total;
    if (i == 0 || burst == 2'b00) return a0;
    if (burst == 2'b11) return AW'(base + ((al - base + i * bytes) % total));
    return AW'(al + i * bytes);
  endfunction

  task automatic run_burst(input string name, input logic [AW-1:0] a, input int len,
                           input int size, input logic [1:0] burst,
                           input logic [IW-1:0] id, input int stall_beat);
    bit illegal, done;
    int beat, stall, rden_cnt, first_v, cyc;
    logic [AW-1:0] ea;
    logic [DW-1:0] h_data;
    logic h_last;
    logic [IW-1:0] h_id;
    beat_t e;
    illegal = (burst == 2'b10) || (size > 2) ||
              (burst == 2'b11 && !(len == 1 || len == 3 || len == 7 || len == 15));
    done = 0; beat = 0; stall = 0; rden_cnt = 0; first_v = -1; cyc = 0;
    for (int i = 0; i <= len; i++) begin
      ea = model_addr(a, len, size, burst, i);
      exp_q.push_back('{illegal ? '0 : mem_word(ea), illegal ? 2'b10 : 2'b00,
                        (i == len), id});
    end
    @(negedge clk);
    for (int k = 0; k < 20 && !arready; k++) @(negedge clk);
    checks++;
    if (arready !== 1'b1) $display("FAIL %s arready_before_ar got=%b want=1", name, arready);
    arvalid = 1'b1; araddr = a; arlen = 8'(len); arsize = 3'(size);
    arburst = burst; arid = id;
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      rready = 1'b1;
      if (rvalid && beat == stall_beat && stall < 5) begin
        rready = 1'b0;
        stall++;
        if (stall == 1) begin
          h_data = rdata; h_last = rlast; h_id = rid;
        end else begin
          checks++;
          if ({rdata, rlast, rid} !== {h_data, h_last, h_id}) begin
            errors++;
            $display("FAIL %s stall_hold got=%h/%b/%h want=%h/%b/%h", name,
                     rdata, rlast, rid, h_data, h_last, h_id);
          end
        end
      end
      if (rd_en) begin
        checks++;
        if (illegal || rden_cnt > len) begin
          errors++;
          $display("FAIL %s unexpected_rd_en addr=%h", name, rd_addr);
        end else if (rd_addr !== model_addr(a, len, size, burst, rden_cnt)) begin
          errors++;
          $display("FAIL %s rd_addr beat%0d got=%h want=%h", name, rden_cnt, rd_addr,
                   model_addr(a, len, size, burst, rden_cnt));
        end
        rden_cnt++;
      end
      if (rvalid && first_v < 0) first_v = cyc;
      if (rvalid && rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat got=%h want=none", name, rdata);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rdata !== e.data) begin
            errors++;
            $display("FAIL %s rdata beat%0d got=%h want=%h", name, beat, rdata, e.data);
          end
          checks++;
          if (rresp !== e.resp) begin
            errors++;
            $display("FAIL %s rresp beat%0d got=%b want=%b", name, beat, rresp, e.resp);
          end
          checks++;
          if (rlast !== e.last) begin
            errors++;
            $display("FAIL %s rlast beat%0d got=%b want=%b", name, beat, rlast, e.last);
          end
          checks++;
          if (rid !== e.id) begin
            errors++;
            $display("FAIL %s rid beat%0d got=%h want=%h", name, beat, rid, e.id);
          end
          beat++;
          if (e.last) done = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got=%0d beats want=%0d", name, beat, len + 1);
      exp_q.delete();
    end
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_last got=arready%b rvalid%b want=arready1 rvalid0",
               name, arready, rvalid);
    end
    checks++;
    if (first_v != (illegal ? 1 : 2)) begin
      errors++;
      $display("FAIL %s first_rvalid_latency got=%0d want=%0d", name, first_v,
               illegal ? 1 : 2);
    end
    checks++;
    if (rden_cnt != (illegal ? 0 : len + 1)) begin
      errors++;
      $display("FAIL %s rd_en_count got=%0d want=%0d", name, rden_cnt,
               illegal ? 0 : len + 1);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({arready, rvalid, rdata, rresp, rlast, rid, rd_en, rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b %h %b%b %h %b %h want=all0", arready, rvalid,
               rdata, rresp, rlast, rid, rd_en, rd_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_arready got=%b want=0", arready);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge_arready got=%b want=1", arready);
    end
  endtask

  task automatic test_reset_mid_burst();
    int hs;
    bit fired;
    hs = 0; fired = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h200; arlen = 8'd7; arsize = 3'd2;
    arburst = 2'b01; arid = 4'h9;
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < 50 && !fired; k++) begin
      if (rvalid && hs == 1) begin
        rst = 1'b1;
        fired = 1;
      end else begin
        if (rvalid) hs++;
        @(negedge clk);
      end
    end
    #1;
    checks++;
    if (!fired || rvalid !== 1'b0 || arready !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_immediate got=fired%0d rvalid%b arready%b rd_en%b want=1 0 0 0",
               fired, rvalid, arready, rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release_arready got=%b want=0", arready);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after_edge got=arready%b rvalid%b want=1 0", arready, rvalid);
    end
    rready = 1'b0;
    run_burst("post_reset_incr", 32'h400, 3, 2, 2'b01, 4'h6, -1);
  endtask

  initial begin
    test_reset();
    run_burst("incr_basic", 32'h100, 3, 2, 2'b01, 4'h5, -1);
    run_burst("wrap_basic", 32'h38, 3, 2, 2'b11, 4'hA, -1);
    run_burst("fixed", 32'h20, 2, 2, 2'b00, 4'h3, -1);
    run_burst("incr_unaligned", 32'h101, 2, 2, 2'b01, 4'hC, -1);
    run_burst("err_reserved", 32'h80, 1, 2, 2'b10, 4'h1, -1);
    run_burst("err_wrap_len2", 32'h40, 2, 2, 2'b11, 4'h2, -1);
    run_burst("err_size3", 32'h60, 1, 3, 2'b01, 4'hF, -1);
    run_burst("backpressure", 32'h300, 3, 2, 2'b01, 4'h7, 1);
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
